muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle signed multiply/divide engine and its controller. Takes the mul/div work off the single-cycle execute ALU. Accepts one operation per start pulse from the execute stage and stalls the pipeline while iterating. Returns a 32-bit result in ALU format: product, or {remainder, quotient}.

Parameters:
WIDTH, 16, operand width; product and {rem,quot} result are 2*WIDTH bits; RUN phase is WIDTH cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
func  input  4  4'b0100 signed multiply, 4'b0101 signed divide; other codes ignored
a  input  WIDTH  operand A (multiplicand / dividend), two's complement
b  input  WIDTH  operand B (multiplier / divisor), two's complement
stall  output  1  freeze upstream pipeline stages
busy  output  1  high in PREP, RUN and FIX
done  output  1  one-cycle pulse; result valid
result  output  2*WIDTH  mul: full signed product; div: {remainder, quotient}
dbz  output  1  divide-by-zero flag; valid with done, held with result

Behaviour:
- Reset (async, active-high): state=IDLE; result=0; done=0; dbz=0; busy=0; stall=0; all internal registers cleared. A reset mid-operation abandons the operation. No done is produced for it.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: start=1 with a valid func latches a, b, func and the operation type, then goes to PREP. Invalid func or start=0: stay in IDLE, no state change.
- PREP (1 cycle): latch sign(a), sign(b) and magnitudes |a|, |b|. Clear the accumulator. Load the iteration counter with WIDTH-1.
- RUN (WIDTH cycles): one radix-2 step per cycle, counter decrements. Counter==0 goes to FIX.
  - Multiply: shift-add over |b| bits.
  - Divide: restoring step; partial remainder is WIDTH+1 bits.
- FIX (1 cycle): apply signs.
  - Product negated iff sign(a)^sign(b).
  - Quotient negated iff sign(a)^sign(b); remainder takes the sign of a (truncating division).
  - Write result register.
- DONE (1 cycle): done=1, then back to IDLE. A start during DONE is ignored.
- Latency: start sampled at edge k gives done high in cycle k+WIDTH+3 (19 cycles for WIDTH=16). Throughput is one operation per WIDTH+4 cycles.
- stall = (IDLE & start & valid func) | PREP | RUN | FIX. The combinational term freezes the requesting instruction in the same cycle it issues. stall is low in DONE so the pipeline captures result that cycle.
- busy = PREP | RUN | FIX (registered state decode).
- start while busy: ignored. Operands and func are not re-latched.
- result and dbz hold their values until the next FIX. They are not cleared by done.
- Divide by zero (b=0): quotient = all ones (0xFFFF), remainder = a, dbz=1. Full latency still applies.
- Overflow divide, most-negative / -1: quotient wraps to 0x8000, remainder = 0, dbz=0.
- Multiply never overflows (full 2*WIDTH result). dbz=0 for every multiply.
- Magnitude of the most-negative operand is handled as an unsigned WIDTH-bit value (0x8000 = 32768).

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: PREP checks for trivial cases and goes straight to DONE, writing result and dbz from PREP.
  - Multiply with a==0 or b==0 gives result 0.
  - Divide with b==0 gives the divide-by-zero result and dbz=1.
  - Divide with a==0 gives result 0.
  - Latency for these cases: done in cycle k+2. stall is low from cycle k+2.
- Undefined: every operation takes the full WIDTH+3 latency. Results are identical in both builds.

Test Plan:
- Multiply a=-3 (0xFFFD), b=7, start at edge k -> stall high k..k+18; done in cycle k+19 only; result=0xFFFFFFEB; dbz=0.
- Divide a=-7 (0xFFF9), b=2 -> result=0xFFFFFFFD (rem -1, quot -3). Divide a=7, b=-2 -> result=0x0001FFFD.
- Divide a=0x1234, b=0 -> result=0x1234FFFF, dbz=1. Latency 19 without the macro, done at k+2 with MULDIV_EARLY_EXIT_EN.
- Divide a=0x8000, b=0xFFFF -> result=0x00008000, dbz=0. Multiply a=0x8000, b=0x8000 -> result=0x40000000.
- Pulse start with func=4'b0000 in IDLE -> no stall, busy stays 0, no done, result unchanged. Pulse start again during RUN with different operands -> ignored, first operation's result delivered.
- Assert rst in RUN cycle 5 -> all outputs 0 immediately. A subsequent multiply 5*6 completes with result=0x0000001E and no spurious done.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer (shift-add / restoring).
// Define MULDIV_EARLY_EXIT_EN to finish trivial operands straight from PREP.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               dbz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;

  logic               req;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shl;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mag, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               neg;

  assign req = start & ((func == F_MUL) | (func == F_DIV));

  assign abs_a = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
  assign abs_b = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;

  // Restoring step: partial remainder is WIDTH+1 bits, borrow in the MSB.
  assign shl  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign diff = {1'b0, shl} - {2'b00, m_q};
  assign sum  = hi_q + (lo_q[0] ? {1'b0, m_q} : '0);

  assign neg  = sa_q ^ sb_q;
  assign mag  = {hi_q[WIDTH-1:0], lo_q};
  assign prod = neg ? (~mag + 1'b1) : mag;
  assign quot = neg ? (~lo_q + 1'b1) : lo_q;
  assign rem  = sa_q ? (~hi_q[WIDTH-1:0] + 1'b1)
                     : hi_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          a_d     = a;
          b_d     = b;
          div_d   = (func == F_DIV);
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sa_d    = a_q[WIDTH-1];
        sb_d    = b_q[WIDTH-1];
        m_d     = div_q ? abs_b : abs_a;
        lo_d    = div_q ? abs_a : abs_b;
        hi_d    = '0;
        cnt_d   = CW'(WIDTH-1);
        state_d = S_RUN;
`ifdef MULDIV_EARLY_EXIT_EN
        if (div_q && b_q == '0) begin
          res_d   = {a_q, {WIDTH{1'b1}}};
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else if (a_q == '0 || b_q == '0) begin
          res_d   = '0;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
`endif
      end
      S_RUN: begin
        if (div_q) begin
          if (!diff[WIDTH+1]) begin
            hi_d = diff[WIDTH:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shl;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = {1'b0, sum[WIDTH:1]};
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (!div_q) begin
          res_d = prod;
          dbz_d = 1'b0;
        end else if (b_q == '0) begin
          res_d = {a_q, {WIDTH{1'b1}}};
          dbz_d = 1'b1;
        end else begin
          res_d = {rem, quot};
          dbz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy   = (state_q == S_PREP) | (state_q == S_RUN)
                | (state_q == S_FIX);
  assign stall  = ((state_q == S_IDLE) & req) | busy;
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expectations queued at issue,
// compared when done pulses, with latency and stall-window checks.
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dbz;
    int             cyc0;
    int             lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [3:0]     func = 4'b0000;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           stall, busy, done, dbz;
  logic [2*W-1:0] result;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t drv_e;
  logic [2*W-1:0] last_res = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .a(a), .b(b), .stall(stall), .busy(busy), .done(done),
    .result(result), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [3:0] f,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    int sx, sy, p, q, r;
    logic triv;
    sx = $signed(x);
    sy = $signed(y);
    if (f == F_MUL) begin
      p     = sx * sy;
      e.res = p[31:0];
      e.dbz = 1'b0;
    end else if (y == '0) begin
      e.res = {x, 16'hFFFF};
      e.dbz = 1'b1;
    end else begin
      q     = sx / sy;
      r     = sx % sy;
      e.res = {r[15:0], q[15:0]};
      e.dbz = 1'b0;
    end
    triv = (y == '0) || (x == '0);
    e.lat = W + 2;
`ifdef MULDIV_EARLY_EXIT_EN
    if (triv) e.lat = 1;
`endif
    if (triv && e.lat == 0) e.lat = 0;
    e.cyc0 = 0;
    return e;
  endfunction

  // Monitor: compare on done, track stall window per operation.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("result", result, mon_e.res);
          check("dbz", dbz, mon_e.dbz);
          check("latency", cyc - mon_e.cyc0, mon_e.lat);
          check("stall_cycles", stall_cnt, mon_e.lat + 1);
          check("stall_in_done", stall, 0);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    func  = f;
    a     = x;
    b     = y;
    if (f == F_MUL || f == F_DIV) begin
      drv_e      = model(f, x, y);
      drv_e.cyc0 = cyc + 1;
      last_res   = drv_e.res;
      sb_q.push_back(drv_e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      check("timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    #12;
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_dbz", dbz, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(F_MUL, 16'hFFFD, 16'd7);        wait_idle();
    check("mul_m3x7", last_res, 32'hFFFFFFEB);
    issue(F_DIV, 16'hFFF9, 16'd2);        wait_idle();
    issue(F_DIV, 16'd7, 16'hFFFE);        wait_idle();
    issue(F_DIV, 16'h1234, 16'h0000);     wait_idle();
    issue(F_DIV, 16'h8000, 16'hFFFF);     wait_idle();
    issue(F_MUL, 16'h8000, 16'h8000);     wait_idle();
    issue(F_MUL, 16'h0000, 16'h1234);     wait_idle();
    issue(F_DIV, 16'h0000, 16'h0003);     wait_idle();

    // Invalid func: nothing happens, result held.
    @(posedge clk);
    #1;
    start = 1'b1;
    func  = 4'b0000;
    a     = 16'h1111;
    b     = 16'h2222;
    #1 check("inv_stall", stall, 0);
    @(posedge clk);
    #1 start = 1'b0;
    check("inv_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 check("inv_hold", result, last_res);

    // Second start during RUN must be ignored.
    issue(F_DIV, 16'd7, 16'hFFFE);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    func  = F_MUL;
    a     = 16'h0055;
    b     = 16'h0066;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1 check("held_after_done", result, 32'h0001FFFD);

    // Reset in RUN cycle 5 abandons the operation.
    issue(F_MUL, 16'd3, 16'd9);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(F_MUL, 16'd5, 16'd6);           wait_idle();
    check("mul_5x6", last_res, 32'h0000001E);

    for (int i = 0; i < 8; i++) begin
      issue((i % 2 == 0) ? F_MUL : F_DIV,
            W'($urandom), W'($urandom_range(0, 40) - 20));
      wait_idle();
    end
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
